// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 vector execution datapath.
//   vec_op_e : 2-bit opcode map driven by the controller on op
//   state_e  : execution-unit sequencing states
//   sat_clip : clamp a signed value into a two's-complement range of 'width' bits
package cvp14_pkg;

    typedef enum logic [1:0] {
        VEC_OP_VADD    = 2'b00,
        VEC_OP_VDOT    = 2'b01,
        VEC_OP_SMUL    = 2'b10,
        VEC_OP_ILLEGAL = 2'b11
    } vec_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Working width for clamping; wide enough for any intermediate sum used here.
    localparam int unsigned CLIP_W = 64;

    function automatic logic signed [CLIP_W-1:0] sat_clip(
        input logic signed [CLIP_W-1:0] value,
        input int unsigned              width
    );
        logic signed [CLIP_W-1:0] hi;
        logic signed [CLIP_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/vec_exec_unit_if.sv
// Controller <-> vector execution unit bus.
//   master : controller side, drives start/op/sat/operands, observes status and results
//   slave  : execution unit side
interface vec_exec_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned VLEN   = 16
) ();

    logic                     start;
    logic [1:0]               op;
    logic                     sat;
    logic [VLEN*DATA_W-1:0]   vec_a;
    logic [VLEN*DATA_W-1:0]   vec_b;
    logic [DATA_W-1:0]        scalar_in;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [VLEN*DATA_W-1:0]   vec_result;
    logic [DATA_W-1:0]        scalar_result;

    modport master (
        output start, op, sat, vec_a, vec_b, scalar_in,
        input  busy, done, err, vec_result, scalar_result
    );

    modport slave (
        input  start, op, sat, vec_a, vec_b, scalar_in,
        output busy, done, err, vec_result, scalar_result
    );

endinterface

// File: rtl/vec_lane.sv
// Single-element combinational datapath.
//   a, b, scalar : signed element operands
//   sat          : 1 = clamp sum/smul to DATA_W signed range, 0 = wrap
//   sum          : a + b
//   smul         : scalar * b (low DATA_W bits, or clamped)
//   prod         : full-precision a * b for the dot-product reduction
module vec_lane
    import cvp14_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic [DATA_W-1:0]          scalar,
    input  logic                       sat,
    output logic [DATA_W-1:0]          sum,
    output logic [DATA_W-1:0]          smul,
    output logic signed [2*DATA_W-1:0] prod
);

    logic signed [DATA_W:0]     sum_full;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] s_ext;
    logic signed [2*DATA_W-1:0] smul_full;
    logic signed [CLIP_W-1:0]   sum_clip;
    logic signed [CLIP_W-1:0]   smul_clip;

    always_comb begin
        sum_full  = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        a_ext     = $signed({{DATA_W{a[DATA_W-1]}}, a});
        b_ext     = $signed({{DATA_W{b[DATA_W-1]}}, b});
        s_ext     = $signed({{DATA_W{scalar[DATA_W-1]}}, scalar});
        prod      = a_ext * b_ext;
        smul_full = s_ext * b_ext;
        sum_clip  = sat_clip(CLIP_W'(sum_full), DATA_W);
        smul_clip = sat_clip(CLIP_W'(smul_full), DATA_W);
        sum       = sat ? DATA_W'(sum_clip) : DATA_W'(sum_full);
        smul      = sat ? DATA_W'(smul_clip) : DATA_W'(smul_full);
    end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execution unit (VADD, VDOT, SMUL), LANES elements per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of vec_exec_unit_if
//              start/op/sat/vec_a/vec_b/scalar_in in; busy/done/err/vec_result/scalar_result out
// Operands are captured on the accept edge; vec_result and scalar_result change only on
// entry to DONE, so partial chunk results never reach the outputs.
module vec_exec_unit
    import cvp14_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned VLEN   = 16,
    parameter int unsigned LANES  = 4,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    vec_exec_unit_if.slave bus
);

    localparam int unsigned NCHUNK = VLEN / LANES;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SUM_W  = 2 * DATA_W + $clog2(LANES);
    localparam int unsigned VEC_W  = VLEN * DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (VLEN % LANES != 0) begin : g_bad_lanes
        $error("vec_exec_unit: VLEN must be a multiple of LANES");
    end
    if (SUM_W + 1 > CLIP_W) begin : g_bad_width
        $error("vec_exec_unit: DATA_W too large for accumulator clamp width");
    end

    state_e                   state;
    vec_op_e                  op_q;
    logic                     sat_q;
    logic [VEC_W-1:0]         a_q;
    logic [VEC_W-1:0]         b_q;
    logic [DATA_W-1:0]        scalar_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [DATA_W-1:0] acc_q;
    logic [VEC_W-1:0]         work_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic [VEC_W-1:0]         vec_res_q;
    logic [DATA_W-1:0]        sc_res_q;

    logic                     sat_eff;
    logic [VEC_W-1:0]         work_next;
    logic signed [DATA_W-1:0] acc_next;
    logic signed [SUM_W-1:0]  chunk_sum;
    logic signed [CLIP_W-1:0] acc_wide;
    logic signed [CLIP_W-1:0] acc_clip;

    logic [DATA_W-1:0]          lane_a    [LANES];
    logic [DATA_W-1:0]          lane_b    [LANES];
    logic [DATA_W-1:0]          lane_sum  [LANES];
    logic [DATA_W-1:0]          lane_smul [LANES];
    logic signed [2*DATA_W-1:0] lane_prod [LANES];

    assign sat_eff = SAT_EN && sat_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        // Element index for lane j in the current chunk.
        assign lane_a[j] = a_q[(int'(cnt_q) * LANES + j) * DATA_W +: DATA_W];
        assign lane_b[j] = b_q[(int'(cnt_q) * LANES + j) * DATA_W +: DATA_W];

        vec_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .a      (lane_a[j]),
            .b      (lane_b[j]),
            .scalar (scalar_q),
            .sat    (sat_eff),
            .sum    (lane_sum[j]),
            .smul   (lane_smul[j]),
            .prod   (lane_prod[j])
        );
    end

    always_comb begin
        chunk_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            chunk_sum = chunk_sum + SUM_W'(lane_prod[j]);
        end
        // Full-precision chunk sum is added to the accumulator, then clamped or wrapped.
        acc_wide = CLIP_W'(acc_q) + CLIP_W'(chunk_sum);
        acc_clip = sat_clip(acc_wide, DATA_W);
        acc_next = sat_eff ? DATA_W'(acc_clip) : DATA_W'(acc_wide);

        work_next = work_q;
        for (int j = 0; j < LANES; j++) begin
            work_next[(int'(cnt_q) * LANES + j) * DATA_W +: DATA_W] =
                (op_q == VEC_OP_SMUL) ? lane_smul[j] : lane_sum[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= VEC_OP_VADD;
            sat_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            scalar_q  <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            vec_res_q <= '0;
            sc_res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= vec_op_e'(bus.op);
                        sat_q    <= bus.sat;
                        a_q      <= bus.vec_a;
                        b_q      <= bus.vec_b;
                        scalar_q <= bus.scalar_in;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (vec_op_e'(bus.op) == VEC_OP_ILLEGAL) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    work_q <= work_next;
                    acc_q  <= acc_next;
                    if (cnt_q == LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                        if (op_q == VEC_OP_VDOT) begin
                            sc_res_q <= acc_next;
                        end else begin
                            vec_res_q <= work_next;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.vec_result    = vec_res_q;
    assign bus.scalar_result = sc_res_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Scoreboard bench for vec_exec_unit: stimulus pushes expected completions, a monitor
// pops and compares on every done pulse and checks result stability while busy.
module tb_vec_exec_unit;

    localparam int DW  = 16;
    localparam int VL  = 16;
    localparam int LN  = 4;
    localparam int NCH = VL / LN;
    localparam int VW  = VL * DW;
    localparam int PER = NCH + 2;

    typedef struct {
        logic [VW-1:0] vec;
        logic [DW-1:0] sc;
        logic          err;
        int            issue;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];

    logic [VW-1:0] mvec;
    logic [DW-1:0] msc;
    logic [VW-1:0] last_vec;
    logic [DW-1:0] last_sc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_exec_unit_if #(.DATA_W(DW), .VLEN(VL)) bus ();

    vec_exec_unit #(
        .DATA_W (DW),
        .VLEN   (VL),
        .LANES  (LN),
        .SAT_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint fit(input longint v, input bit s);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -hi - 1;
        if (s && v > hi) return hi;
        if (s && v < lo) return lo;
        return v;
    endfunction

    function automatic longint el(input logic [VW-1:0] v, input int i);
        logic [DW-1:0] t;
        t = v[i*DW +: DW];
        return longint'($signed(t));
    endfunction

    task automatic model_push(input logic [1:0] op, input bit s, input logic [VW-1:0] a,
                              input logic [VW-1:0] b, input logic [DW-1:0] sc, input int issue);
        exp_t   e;
        longint t;
        longint acc;
        longint cs;
        e.err   = 1'b0;
        e.lat   = NCH + 1;
        e.issue = issue;
        case (op)
            2'd0: for (int i = 0; i < VL; i++) begin
                t = fit(el(a, i) + el(b, i), s);
                mvec[i*DW +: DW] = t[DW-1:0];
            end
            2'd2: for (int i = 0; i < VL; i++) begin
                t = fit(longint'($signed(sc)) * el(b, i), s);
                mvec[i*DW +: DW] = t[DW-1:0];
            end
            2'd1: begin
                acc = 0;
                for (int c = 0; c < NCH; c++) begin
                    cs = 0;
                    for (int j = 0; j < LN; j++) cs += el(a, c*LN + j) * el(b, c*LN + j);
                    acc = fit(acc + cs, s);
                end
                msc = acc[DW-1:0];
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        e.vec = mvec;
        e.sc  = msc;
        expq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            last_vec = '0;
            last_sc  = '0;
        end else if (bus.done) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want no completion", cyc);
            end else begin
                e = expq.pop_front();
                chk("vec_result", bus.vec_result, e.vec);
                chk("scalar_result", VW'(bus.scalar_result), VW'(e.sc));
                chk("err", VW'(bus.err), VW'(e.err));
                chk("latency", VW'(cyc - e.issue), VW'(e.lat));
                last_vec = e.vec;
                last_sc  = e.sc;
            end
        end else if (bus.busy) begin
            chk("hold_vec", bus.vec_result, last_vec);
            chk("hold_scalar", VW'(bus.scalar_result), VW'(last_sc));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] rnd_el();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VL; i++) v[i*DW +: DW] = rnd_el();
        return v;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", bus.busy, n);
        end
    endtask

    task automatic drive(input logic [1:0] op, input bit s, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [DW-1:0] sc);
        bus.op        = op;
        bus.sat       = s;
        bus.vec_a     = a;
        bus.vec_b     = b;
        bus.scalar_in = sc;
        bus.start     = 1'b1;
    endtask

    task automatic issue(input logic [1:0] op, input bit s, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [DW-1:0] sc);
        wait_idle();
        drive(op, s, a, b, sc);
        model_push(op, s, a, b, sc, cyc);
        @(negedge clk);
        bus.start     = 1'b0;
        // Operands must have been captured; scramble them.
        bus.vec_a     = ~a;
        bus.vec_b     = rnd_vec();
        bus.scalar_in = ~sc;
        bus.op        = 2'(~op);
        bus.sat       = ~s;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] r;
        int            t0;
        logic [1:0]    op;
        bit            s;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.sat = 1'b0;
        bus.vec_a = '0; bus.vec_b = '0; bus.scalar_in = '0;
        mvec = '0; msc = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", VW'(bus.busy), '0);
        chk("rst_done", VW'(bus.done), '0);
        chk("rst_err", VW'(bus.err), '0);
        chk("rst_vec", bus.vec_result, '0);
        chk("rst_scalar", VW'(bus.scalar_result), '0);
        rst = 1'b0;

        // VADD wrap / saturate
        for (int i = 0; i < VL; i++) begin
            a[i*DW +: DW] = DW'(i);
            b[i*DW +: DW] = 16'h7FFF;
        end
        issue(2'd0, 1'b0, a, b, '0);
        wait_idle();
        r = bus.vec_result[1*DW +: DW];
        chk("vadd_wrap_r1", VW'(r), VW'(16'h8000));
        r = bus.vec_result[15*DW +: DW];
        chk("vadd_wrap_r15", VW'(r), VW'(16'h800E));
        issue(2'd0, 1'b1, a, b, '0);
        wait_idle();
        r = bus.vec_result[15*DW +: DW];
        chk("vadd_sat_r15", VW'(r), VW'(16'h7FFF));
        for (int i = 0; i < VL; i++) begin
            a[i*DW +: DW] = 16'h8000;
            b[i*DW +: DW] = 16'hFFFF;
        end
        issue(2'd0, 1'b1, a, b, '0);

        // VDOT
        for (int i = 0; i < VL; i++) begin
            a[i*DW +: DW] = DW'(i + 1);
            b[i*DW +: DW] = 16'd2;
        end
        issue(2'd1, 1'b0, a, b, '0);
        wait_idle();
        chk("vdot_272", VW'(bus.scalar_result), VW'(16'h0110));
        for (int i = 0; i < VL; i++) a[i*DW +: DW] = 16'h0100;
        issue(2'd1, 1'b1, a, a, '0);
        wait_idle();
        chk("vdot_sat", VW'(bus.scalar_result), VW'(16'h7FFF));
        issue(2'd1, 1'b0, a, a, '0);

        // SMUL
        for (int i = 0; i < VL; i++) b[i*DW +: DW] = DW'(i);
        issue(2'd2, 1'b0, rnd_vec(), b, 16'hFFFD);
        wait_idle();
        r = bus.vec_result[5*DW +: DW];
        chk("smul_r5", VW'(r), VW'(16'hFFF1));

        // Illegal op, then start while busy is ignored
        issue(2'd3, 1'b0, rnd_vec(), rnd_vec(), 16'h1234);
        issue(2'd0, 1'b0, rnd_vec(), rnd_vec(), '0);
        @(negedge clk);
        drive(2'd1, 1'b1, rnd_vec(), rnd_vec(), rnd_el());
        @(negedge clk);
        bus.start = 1'b0;

        // Start held high: one accept every PER cycles
        wait_idle();
        a = rnd_vec();
        b = rnd_vec();
        op = 2'($urandom_range(0, 2));
        s = 1'($urandom_range(0, 1));
        drive(op, s, a, b, rnd_el());
        t0 = cyc;
        for (int k = 0; k < 3; k++) model_push(op, s, a, b, bus.scalar_in, t0 + k * PER);
        repeat (2 * PER + 1) @(negedge clk);
        bus.start = 1'b0;

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            issue(op, s, rnd_vec(), rnd_vec(), rnd_el());
        end

        // Reset in the second RUN cycle abandons the op
        wait_idle();
        drive(2'd0, 1'b0, rnd_vec(), rnd_vec(), '0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expq.delete();
        mvec = '0;
        msc  = '0;
        #1;
        chk("midrst_busy", VW'(bus.busy), '0);
        chk("midrst_done", VW'(bus.done), '0);
        chk("midrst_vec", bus.vec_result, '0);
        chk("midrst_scalar", VW'(bus.scalar_result), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (NCH + 3) @(negedge clk);
        issue(2'd0, 1'b1, rnd_vec(), rnd_vec(), '0);
        issue(2'd1, 1'b1, rnd_vec(), rnd_vec(), '0);

        wait_idle();
        repeat (3) @(negedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL pending: got %0d outstanding completions, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
